// File: rtl/ex_trap_unit.sv
// Execute-stage trap controller: merges ALU exceptions, a synchronised external interrupt and MRET,
// owns the machine trap CSRs and issues a one-cycle registered flush/redirect into IF.
module ex_trap_unit #(
    parameter logic [31:0] MTVEC_DEFAULT   = 32'h0000_0080,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_overflow,
    input  logic        ex_div_by_zero,
    input  logic        ex_mret,
    input  logic        ext_irq,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap_flush,
    output logic        trap_redirect,
    output logic [31:0] trap_target
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_DIV0 = 32'd10;
    localparam logic [31:0] CAUSE_OVF  = 32'd11;
    localparam logic [31:0] CAUSE_IRQ  = 32'h8000_000B;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IRQ_SYNC_STAGES-1:0] r_irq_sync;
    logic                       r_mie;
    logic                       r_mpie;
    logic [31:0]                r_mtvec;
    logic [31:0]                r_mepc;
    logic [31:0]                r_mcause;
    logic [31:0]                r_target;

    logic        w_irq_s;
    logic        w_irq_pend;
    logic        w_accept;
    logic        w_trap;
    logic        w_mret;
    logic [31:0] w_cause;
    logic        w_csr_wr;
    logic        w_wr_mstatus;
    logic        w_wr_mtvec;
    logic        w_wr_mepc;
    logic        w_wr_mcause;

    assign w_irq_s    = r_irq_sync[IRQ_SYNC_STAGES-1];
    assign w_irq_pend = w_irq_s & r_mie;

    // Event decode; only a real instruction in RUN can raise anything, bubbles are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_trap      = 1'b0;
        w_mret      = 1'b0;
        w_cause     = CAUSE_IRQ;
        case (r_state)
            S_RUN: begin
                w_accept = ex_valid;
                w_trap   = ex_valid & (ex_div_by_zero | ex_overflow | w_irq_pend);
                w_mret   = ex_valid & ex_mret & ~w_trap;
                if (ex_div_by_zero) begin
                    w_cause = CAUSE_DIV0;
                end else if (ex_overflow) begin
                    w_cause = CAUSE_OVF;
                end
                if (w_trap || w_mret) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Trap/MRET updates own a CSR for that cycle, so a colliding software write is dropped.
    assign w_csr_wr     = (r_state == S_RUN) & csr_we;
    assign w_wr_mstatus = w_csr_wr & (csr_addr == CSR_MSTATUS) & ~w_trap & ~w_mret;
    assign w_wr_mtvec   = w_csr_wr & (csr_addr == CSR_MTVEC);
    assign w_wr_mepc    = w_csr_wr & (csr_addr == CSR_MEPC) & ~w_trap;
    assign w_wr_mcause  = w_csr_wr & (csr_addr == CSR_MCAUSE) & ~w_trap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_sync <= '0;
        end else begin
            r_irq_sync <= {r_irq_sync[IRQ_SYNC_STAGES-2:0], ext_irq};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtvec  <= MTVEC_DEFAULT;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_target <= '0;
        end else begin
            if (w_trap) begin
                r_mepc   <= ex_pc;
                r_mcause <= w_cause;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
                r_target <= {r_mtvec[31:2], 2'b00};
            end else if (w_mret) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
                r_target <= r_mepc;
            end
            if (w_wr_mstatus) begin
                r_mie  <= csr_wdata[3];
                r_mpie <= csr_wdata[7];
            end
            if (w_wr_mtvec) begin
                r_mtvec <= csr_wdata;
            end
            if (w_wr_mepc) begin
                r_mepc <= {csr_wdata[31:2], 2'b00};
            end
            if (w_wr_mcause) begin
                r_mcause <= csr_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
            CSR_MTVEC:   csr_rdata = r_mtvec;
            CSR_MEPC:    csr_rdata = r_mepc;
            CSR_MCAUSE:  csr_rdata = r_mcause;
            CSR_MIP:     csr_rdata = {20'd0, w_irq_s, 11'd0};
            default:     csr_rdata = '0;
        endcase
    end

    assign trap_flush    = (r_state == S_FLUSH);
    assign trap_redirect = (r_state == S_FLUSH);
    assign trap_target   = r_target;

endmodule

// File: doc/ex_trap_unit.md
Name: ex_trap_unit

Overview:
- Execute-stage trap controller. It sits directly downstream of the ALU and consumes its div_by_zero and overflow flags together with the EX-stage PC.
- Merges those exceptions with a synchronised external interrupt and with MRET, and owns the machine CSRs mstatus.MIE/MPIE, mtvec, mepc, mcause and mip.
- Drives the pipeline flush and PC-redirect request into the IF stage.

Parameters:
- MTVEC_DEFAULT, 32'h0000_0080, reset value of mtvec.
- IRQ_SYNC_STAGES, 2, flip-flop depth of the ext_irq synchroniser (legal range 2-4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- ex_pc  in  32  PC of the EX-stage instruction.
- ex_overflow  in  1  ALU signed add/sub overflow.
- ex_div_by_zero  in  1  ALU divide-by-zero.
- ex_mret  in  1  EX instruction is MRET.
- ext_irq  in  1  external interrupt, asynchronous, level.
- csr_we  in  1  CSR write strobe from EX.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  CSR read data, combinational.
- trap_flush  out  1  flush IF/ID/EX.
- trap_redirect  out  1  load trap_target into the PC.
- trap_target  out  32  redirect PC.

Behaviour:
- Reset (async): state=RUN, mtvec=MTVEC_DEFAULT, mepc=0, mcause=0, MIE=0, MPIE=0, synchroniser=0, trap_flush=0, trap_redirect=0, trap_target=0.
- irq_s is ext_irq after IRQ_SYNC_STAGES flops. An interrupt is pending when irq_s & MIE.

State machine:
- RUN to FLUSH (trap event accepted at edge N).
- RUN to FLUSH (MRET accepted).
- FLUSH to RUN unconditionally after one cycle.

Events in RUN, sampled only when ex_valid=1 (bubbles are ignored), priority highest first:
- ex_div_by_zero: mcause=32'd10.
- ex_overflow: mcause=32'd11.
- irq pending: mcause=32'h8000_000B.
- ex_mret.

Trap entry:
- mepc<=ex_pc; the EX instruction is discarded, including for interrupts.
- MPIE<=MIE, MIE<=0.
- trap_target<=mtvec with bits [1:0] cleared (direct mode only).

MRET:
- trap_target<=mepc.
- MIE<=MPIE, MPIE<=1.

FLUSH state:
- trap_flush=trap_redirect=1 for exactly one cycle (registered, latency 1 cycle after the event edge).
- All EX inputs and csr_we are ignored.

General rules:
- Exceptions are taken regardless of MIE, including inside a handler; mepc and mcause are overwritten.
- Interrupts are masked while MIE=0.

CSR map:
- 0x300 mstatus: bit3=MIE, bit7=MPIE, all other bits read 0.
- 0x305 mtvec.
- 0x341 mepc: bits [1:0] forced 0 on write.
- 0x342 mcause.
- 0x344 mip: bit11=irq_s, read-only.
- Unmapped addresses read 0 and ignore writes.

CSR write rules:
- csr_we takes effect at the next edge.
- A same-cycle trap or MRET update of the same CSR wins over csr_we, and that csr_we is dropped entirely.

Test Plan:
- Exception entry: mtvec=0x80, ex_valid=1, ex_pc=0x40, ex_overflow=1 -> next cycle trap_flush=trap_redirect=1, trap_target=0x80. The following cycle both outputs are 0. mepc=0x40, mcause=11.
- Exception beats interrupt: MIE=1, ext_irq held high, then ex_pc=0x100 with ex_div_by_zero=1 in the same cycle -> mcause=10, mepc=0x100, MIE=0, MPIE=1.
- Interrupt masking and timing: ext_irq=1 with MIE=0 -> no trap for 10 cycles. Then write mstatus=0x8 via CSR -> trap on the first ex_valid cycle afterwards, mcause=0x8000_000B, mepc=ex_pc of that instruction, mip bit11=1.
- MRET: mepc=0x200, MPIE=1, ex_mret=1 -> trap_target=0x200 one cycle later, MIE=1, MPIE=1.
- Bubble filtering: ex_valid=0 with ex_overflow=1 -> no flush, no CSR change. Also csr_we to 0x342 in the same cycle as an accepted overflow -> mcause=11 and the CSR write is lost.
- Reset during FLUSH: assert rst mid-cycle while trap_flush=1 -> outputs drop to 0 immediately without waiting for a clock edge. mtvec=0x80, MIE=0.
